// File: rtl/ram_arbiter.sv
// Arbitrates one RAM port between the core and a FIFO of buffered JTAG debug writes.
// Define RAM_ARB_HALT_GATE_EN to drain JTAG writes only while the core is halted.
module ram_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [3:0]                      core_wen,
   input  logic                            core_ren,
   input  logic [AW-1:0]                   core_addr,
   input  logic [DW-1:0]                   core_wdata,
   output logic [DW-1:0]                   core_rdata,
   output logic                            core_busy,
   input  logic                            jtag_we,
   input  logic [AW-1:0]                   jtag_addr,
   input  logic [DW-1:0]                   jtag_wdata,
   input  logic                            jtag_halt,
   output logic [3:0]                      ram_wen,
   output logic                            ram_ren,
   output logic [AW-1:0]                   ram_addr,
   output logic [DW-1:0]                   ram_wdata,
   input  logic [DW-1:0]                   ram_rdata,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            jtag_ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [AW+DW-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    level;
   logic [SW-1:0]    starve_cnt;
   logic             rd_q;
   logic             ovf_q;

   logic core_req;
   logic nonempty;
   logic full;
   logic starved;
   logic jtag_gnt;
   logic push;
   logic pop;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;

   assign core_req  = core_ren | (|core_wen);
   assign nonempty  = (level != '0);
   assign full      = (level == LW'(FIFO_DEPTH));
   assign starved   = (starve_cnt == SW'(STARVE_MAX));
   assign head_addr = fifo_mem[rd_ptr][AW+DW-1:DW];
   assign head_data = fifo_mem[rd_ptr][DW-1:0];

   // A grant that would stall the core is withheld on the cycle after an accepted
   // read, so the core is never told busy while its read data is returning.
   always_comb begin
      jtag_gnt = 1'b0;
`ifdef RAM_ARB_HALT_GATE_EN
      jtag_gnt = nonempty & jtag_halt & ~(rd_q & core_req);
`else
      jtag_gnt = nonempty & (~core_req | (~rd_q & (starved | jtag_halt)));
`endif
      if (rst)
         jtag_gnt = 1'b0;
   end

   assign pop  = jtag_gnt;
   assign push = jtag_we & (~full | pop);

   always_comb begin
      ram_wen   = core_wen;
      ram_ren   = core_ren;
      ram_addr  = core_addr;
      ram_wdata = core_wdata;
      core_busy = 1'b0;
      if (rst) begin
         ram_wen = 4'h0;
         ram_ren = 1'b0;
      end else if (jtag_gnt) begin
         ram_wen   = 4'hF;
         ram_ren   = 1'b0;
         ram_addr  = head_addr;
         ram_wdata = head_data;
         core_busy = core_req;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {jtag_addr, jtag_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         starve_cnt <= '0;
         rd_q       <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (jtag_we & full & ~pop)
            ovf_q <= 1'b1;
         if (jtag_gnt | ~nonempty)
            starve_cnt <= '0;
         else if (core_req & ~starved)
            starve_cnt <= starve_cnt + 1'b1;
         rd_q <= core_ren & ~jtag_gnt;
      end
   end

   assign core_rdata = ram_rdata;
   assign fifo_level = level;
   assign jtag_ovf   = ovf_q;

endmodule
